// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared ALU opcodes, function codes and FSM states for muldiv_sequencer.
// `MULDIV_SIGNED_EN widens the function code and adds the sign-fix state.
package muldiv_pkg;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0100;
`ifdef MULDIV_SIGNED_EN
    localparam int FUNCT_W = 3;
    typedef enum logic [2:0] {F_MUL, F_MULHU, F_DIVU, F_REMU, F_MULH, F_MULHSU, F_DIV, F_REM} muldiv_funct_e;
    typedef enum logic [2:0] {IDLE, STEP, FINISH, FIX, DONE} muldiv_state_e;
`else
    localparam int FUNCT_W = 2;
    typedef enum logic [1:0] {F_MUL, F_MULHU, F_DIVU, F_REMU} muldiv_funct_e;
    typedef enum logic [1:0] {IDLE, STEP, FINISH, DONE} muldiv_state_e;
`endif
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: pipeline request/response and shared-ALU hookup of muldiv_sequencer.
// master = pipeline + ALU side, slave = the sequencer.
interface muldiv_sequencer_if #(parameter int DATA_WIDTH = 32, parameter int OPCODE_LENGTH = 4);
    import muldiv_pkg::*;
    logic start;
    muldiv_funct_e funct;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic busy;
    logic done;
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] alu_src_a;
    logic [DATA_WIDTH-1:0] alu_src_b;
    logic [OPCODE_LENGTH-1:0] alu_operation;
    logic [DATA_WIDTH-1:0] alu_result;
    modport master (output start, funct, op_a, op_b, alu_result,
                    input busy, done, result, alu_src_a, alu_src_b, alu_operation);
    modport slave (input start, funct, op_a, op_b, alu_result,
                   output busy, done, result, alu_src_a, alu_src_b, alu_operation);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide that borrows the execute-stage ALU, one bit per clock.
// `MULDIV_SIGNED_EN adds MULH/MULHSU/DIV/REM with a trailing sign-fix cycle.
module muldiv_sequencer import muldiv_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input logic clk,
    input logic rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    muldiv_state_e state, state_n;
    logic [FUNCT_W-1:0] fq, f_in;
    logic [DATA_WIDTH-1:0] hi, lo, dvs, res, r_sh, fin, a_abs, b_abs;
    logic [DATA_WIDTH:0] add_hi;
    logic [CW-1:0] cnt;
    logic div0, is_div, ge, b_zero, start_div, hi_sel;

    assign f_in = bus.funct;
    assign is_div = fq[1];
    assign b_zero = bus.op_b == '0;
    assign start_div = f_in[1] & b_zero;
    // {Hi,Lo} shifted left by one; ge also accounts for the bit shifted out of R
    assign r_sh = {hi[DATA_WIDTH-2:0], lo[DATA_WIDTH-1]};
    assign ge = hi[DATA_WIDTH-1] | (r_sh >= dvs);
    assign add_hi = lo[0] ? {bus.alu_result < hi, bus.alu_result} : {1'b0, hi};
    assign fin = div0 ? (fq[0] ? lo : '1) : (hi_sel ? hi : lo);

`ifdef MULDIV_SIGNED_EN
    logic neg, neg_d, a_neg, b_neg, mulh;
    assign a_neg = f_in[2] & bus.op_a[DATA_WIDTH-1];
    assign b_neg = f_in[2] & (f_in[1:0] != 2'b01) & bus.op_b[DATA_WIDTH-1];
    assign a_abs = a_neg ? -bus.op_a : bus.op_a;
    assign b_abs = b_neg ? -bus.op_b : bus.op_b;
    // remainder follows the dividend sign; a zero divisor leaves the all-ones quotient alone
    assign neg_d = f_in[2] & (a_neg ^ (b_neg & (f_in[1:0] != 2'b11))) & ~((f_in[1:0] == 2'b10) & b_zero);
    assign mulh = fq[2] & ~fq[1];
    assign hi_sel = fq[0] | mulh;
`else
    assign a_abs = bus.op_a;
    assign b_abs = bus.op_b;
    assign hi_sel = fq[0];
`endif

    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    assign bus.result = res;

    always_comb begin
        bus.alu_src_a = '0;
        bus.alu_src_b = '0;
        bus.alu_operation = OPCODE_LENGTH'(ALU_ADD);
        if (state == STEP) begin
            bus.alu_src_a = is_div ? r_sh : hi;
            bus.alu_src_b = dvs;
            bus.alu_operation = OPCODE_LENGTH'(is_div ? ALU_SUB : ALU_ADD);
        end
`ifdef MULDIV_SIGNED_EN
        // 64-bit negate of the high word: ~Hi + (Lo == 0), i.e. (Lo ? -1 : 0) - Hi
        else if (state == FIX) begin
            bus.alu_src_a = (mulh && lo != '0) ? '1 : '0;
            bus.alu_src_b = mulh ? hi : res;
            bus.alu_operation = OPCODE_LENGTH'(ALU_SUB);
        end
`endif
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = bus.start ? (start_div ? FINISH : STEP) : IDLE;
            STEP: state_n = cnt == '0 ? FINISH : STEP;
`ifdef MULDIV_SIGNED_EN
            FINISH: state_n = FIX;
            FIX: state_n = DONE;
`else
            FINISH: state_n = DONE;
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq <= '0;
            hi <= '0;
            lo <= '0;
            dvs <= '0;
            res <= '0;
            cnt <= '0;
            div0 <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    fq <= f_in;
                    hi <= '0;
                    lo <= a_abs;
                    dvs <= b_abs;
                    cnt <= CW'(DATA_WIDTH - 1);
                    div0 <= start_div;
`ifdef MULDIV_SIGNED_EN
                    neg <= neg_d;
`endif
                end
                STEP: begin
                    cnt <= cnt - 1'b1;
                    if (is_div) begin
                        hi <= ge ? bus.alu_result : r_sh;
                        lo <= {lo[DATA_WIDTH-2:0], ge};
                    end else {hi, lo} <= {add_hi, lo[DATA_WIDTH-1:1]};
                end
                FINISH: res <= fin;
`ifdef MULDIV_SIGNED_EN
                FIX: if (neg) res <= bus.alu_result;
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed checks of muldiv_sequencer (unsigned build) against a
// plain-arithmetic reference, with a behavioural ADD/SUB ALU closing the loop.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;
    localparam int DW = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    muldiv_sequencer_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(4)) bus();
    muldiv_sequencer #(.DATA_WIDTH(DW), .OPCODE_LENGTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    always_comb
        bus.alu_result = bus.alu_operation == 4'b0010 ? bus.alu_src_a + bus.alu_src_b :
                         bus.alu_operation == 4'b0100 ? bus.alu_src_a - bus.alu_src_b : '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (f)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
            2'd2: return b == 0 ? 32'hFFFF_FFFF : a / b;
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        int n;
        int lat;
        logic [31:0] exp;
        exp = model(f, a, b);
        lat = (f[1] && b == 0) ? 2 : DW + 2;
        @(negedge clk);
        bus.start = 1'b1;
        bus.funct = muldiv_funct_e'(f);
        bus.op_a = a;
        bus.op_b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_a = $urandom;
        bus.op_b = $urandom;
        n = 1;
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        while (!bus.done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " result"}, bus.result, exp);
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, 32'({bus.busy, bus.done}), 32'd0);
    endtask

    initial begin
        int dn;
        int dlat;
        logic [31:0] dres;
        logic [31:0] held;
        logic [1:0] f;
        logic [31:0] a;
        logic [31:0] b;
        bus.start = 1'b0;
        bus.funct = F_MUL;
        bus.op_a = '0;
        bus.op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset alu_op", 32'(bus.alu_operation), 32'h2);
        check("reset alu_src", bus.alu_src_a | bus.alu_src_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_7x6", 2'd0, 32'd7, 32'd6);
        check("mul_7x6 const", bus.result, 32'd42);
        run_op("mulhu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulhu_ff const", bus.result, 32'hFFFF_FFFE);
        run_op("mul_ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mul_ff const", bus.result, 32'd1);
        run_op("divu_100_7", 2'd2, 32'd100, 32'd7);
        check("divu_100_7 const", bus.result, 32'd14);
        run_op("remu_100_7", 2'd3, 32'd100, 32'd7);
        check("remu_100_7 const", bus.result, 32'd2);
        run_op("divu_5_0", 2'd2, 32'd5, 32'd0);
        run_op("remu_5_0", 2'd3, 32'd5, 32'd0);
        held = bus.result;
        repeat (3) @(posedge clk);
        #1;
        check("result held", bus.result, held);

        // Start kept high through the whole operation, including the DONE cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.funct = F_DIVU;
        bus.op_a = 32'd1000;
        bus.op_b = 32'd9;
        @(posedge clk);
        #1;
        check("div step alu_op", 32'(bus.alu_operation), 32'h4);
        bus.funct = F_MUL;
        bus.op_a = $urandom;
        bus.op_b = $urandom;
        dn = 0;
        dlat = 0;
        dres = '0;
        for (int n = 2; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                dn++;
                dlat = n;
                dres = bus.result;
            end
            if (n == DW + 3) begin
                check("ignore busy after done", 32'(bus.busy), 32'd0);
                bus.start = 1'b0;
            end
        end
        check("ignore done count", 32'(dn), 32'd1);
        check("ignore latency", 32'(dlat), 32'(DW + 2));
        check("ignore result", dres, model(2'd2, 32'd1000, 32'd9));

        // Abort a multiply part way through its steps
        @(negedge clk);
        bus.start = 1'b1;
        bus.funct = F_MUL;
        bus.op_a = 32'd123456;
        bus.op_b = 32'd789;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort result", bus.result, 32'd0);
        check("abort alu_op", 32'(bus.alu_operation), 32'h2);
        check("abort alu_src", bus.alu_src_a | bus.alu_src_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mul_after_abort", 2'd0, 32'd123456, 32'd789);

        for (int i = 0; i < 24; i++) begin
            f = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), f, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
